// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad scanner:
//   state_t    - scan controller FSM states (SCAN -> EVAL -> PUSH -> SCAN)
//   code_width - width needed to index n items (never less than 1 bit)
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_EVAL = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// -----------------------------------------------------------------------------
// keypad_event_fifo
// Synchronous show-ahead FIFO for key events. The head entry is always visible
// on rd_data. A write into a full FIFO is accepted only when a read happens in
// the same cycle; otherwise it is ignored, and the caller flags the drop.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en        - write request, wr_data - entry to write
//   rd_en        - pop the head entry, rd_data - head entry
//   full, empty  - occupancy flags
// -----------------------------------------------------------------------------
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = code_width(DEPTH);
  localparam int NW = code_width(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == NW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it has been
  // written, and the top masks rd_data while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Scans a ROWS x COLS active-low key matrix one row at a time, debounces the
// whole-matrix frame, and queues one event per newly pressed key
// (code = row*COLS + col) in ascending code order.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat of a single
// held key (REPEAT_DELAY frames to first repeat, then every REPEAT_RATE).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   row_out     - row drive, active-low, at most one bit low
//   col_in      - column sense, active-low, asynchronous to clk
//   key_code    - code of the head event
//   key_valid   - head event available
//   key_ready   - consumer accepts the head event
//   key_repeat  - head event is an auto-repeat
//   overflow    - one-cycle pulse when an event is dropped
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_TIME      = 50_000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_RATE    = 5
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [ROWS-1:0]                   row_out,
  input  logic [COLS-1:0]                   col_in,
  output logic [code_width(ROWS*COLS)-1:0]  key_code,
  output logic                              key_valid,
  input  logic                              key_ready,
  output logic                              key_repeat,
  output logic                              overflow
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CW    = code_width(NKEYS);
  localparam int TW    = code_width(SCAN_TIME);
  localparam int RW    = code_width(ROWS);
  localparam int SW    = code_width(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
  localparam int EW    = CW + 1;
`else
  localparam int EW    = CW;
`endif

  state_t            state, state_next;
  logic [COLS-1:0]   col_meta, col_sync;
  logic [TW-1:0]     scan_cnt;
  logic [RW-1:0]     row_idx, row_next;
  logic [NKEYS-1:0]  frame, prev_frame, deb_map, map_next, pending, pend_onehot;
  logic [SW-1:0]     stable_cnt, stable_next;
  logic [CW-1:0]     pend_lo;
  logic              scan_last, row_last, has_evt, push_en, pop, fifo_full, fifo_empty;
  logic [EW-1:0]     push_data, head;

  // Two-flop synchronizer; idle (all ones) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign scan_last = (scan_cnt == TW'(SCAN_TIME - 1));
  assign row_last  = (row_idx == RW'(ROWS - 1));
  assign row_next  = (state == ST_SCAN && scan_last) ? (row_last ? '0 : row_idx + 1'b1) : row_idx;

  // A frame identical to the previous one extends the stable run; the map is
  // (re)loaded whenever the run is long enough.
  assign stable_next = (frame != prev_frame) ? '0 :
                       (stable_cnt == SW'(DEBOUNCE_SCANS - 1)) ? stable_cnt : stable_cnt + 1'b1;
  assign map_next    = (stable_next == SW'(DEBOUNCE_SCANS - 1)) ? frame : deb_map;

  // Lowest pending press is pushed first, giving ascending code order.
  assign pend_onehot = pending & (~pending + NKEYS'(1));
  always_comb begin
    pend_lo = '0;
    for (int i = 0; i < NKEYS; i++) if (pend_onehot[i]) pend_lo = CW'(i);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = code_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic [RPW-1:0] rep_cnt, rep_limit;
  logic           rep_phase, rep_pending, map_single;
  logic [CW-1:0]  map_lo;

  assign map_single = (map_next != '0) && ((map_next & (map_next - 1'b1)) == '0);
  assign rep_limit  = rep_phase ? RPW'(REPEAT_RATE - 1) : RPW'(REPEAT_DELAY - 1);

  always_comb begin
    map_lo = '0;
    for (int i = 0; i < NKEYS; i++) if (deb_map[i]) map_lo = CW'(i);
  end

  // Frame-based repeat timer; any change of the debounced map restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      rep_phase   <= 1'b0;
      rep_pending <= 1'b0;
    end else if (state == ST_EVAL) begin
      rep_pending <= 1'b0;
      if (!map_single || map_next != deb_map) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (rep_cnt == rep_limit) begin
        rep_cnt     <= '0;
        rep_phase   <= 1'b1;
        rep_pending <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end else if (state == ST_PUSH && pending == '0) begin
      rep_pending <= 1'b0;
    end
  end

  assign has_evt = (pending != '0) || rep_pending;
`else
  assign has_evt = (pending != '0);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    push_en    = 1'b0;
    push_data  = '0;
    case (state)
      ST_SCAN: if (scan_last && row_last) state_next = ST_EVAL;
      ST_EVAL: state_next = ST_PUSH;
      ST_PUSH: begin
        if (pending != '0) begin
          push_en   = 1'b1;
          push_data = EW'(pend_lo);
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_pending) begin
          push_en   = 1'b1;
          push_data = {1'b1, map_lo};
        end
`endif
        if (!has_evt) state_next = ST_SCAN;
      end
      default: state_next = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SCAN;
      row_out  <= '1;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      row_out  <= (state_next == ST_SCAN) ? ~(ROWS'(1) << row_next) : '1;
      overflow <= push_en && fifo_full && !pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      row_idx    <= '0;
      frame      <= '0;
      prev_frame <= '0;
      deb_map    <= '0;
      pending    <= '0;
      stable_cnt <= '0;
    end else begin
      case (state)
        ST_SCAN: begin
          scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
          row_idx  <= row_next;
          if (scan_last) frame[int'(row_idx)*COLS +: COLS] <= ~col_sync;
        end
        ST_EVAL: begin
          prev_frame <= frame;
          stable_cnt <= stable_next;
          deb_map    <= map_next;
          pending    <= map_next & ~deb_map;
        end
        ST_PUSH: pending <= pending & ~pend_onehot;
        default: ;
      endcase
    end
  end

  assign pop = !fifo_empty && key_ready;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_en),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign key_valid = !fifo_empty;
  assign key_code  = fifo_empty ? '0 : head[CW-1:0];
`ifdef KEYPAD_REPEAT_EN
  assign key_repeat = !fifo_empty && head[CW];
`else
  assign key_repeat = 1'b0;
`endif

endmodule
